// File: rtl/assist_drive_pipe_if.sv
// assist_drive_pipe_if: sample-in / current-demand-out bundle for the assist drive pipeline
interface assist_drive_pipe_if #(
  parameter int TORQUE_W = 12,
  parameter int CURR_W   = 12
);
  logic                in_vld;
  logic [TORQUE_W-1:0] avg_torque;
  logic [4:0]          cadence;
  logic                not_pedaling;
  logic [12:0]         incline;
  logic [2:0]          scale;
  logic                ramp_en;
  logic [CURR_W-1:0]   target_curr;
  logic                out_vld;
  logic                sat;
  modport master (
    output in_vld, avg_torque, cadence, not_pedaling, incline, scale, ramp_en,
    input  target_curr, out_vld, sat
  );
  modport slave (
    input  in_vld, avg_torque, cadence, not_pedaling, incline, scale, ramp_en,
    output target_curr, out_vld, sat
  );
endinterface

// File: rtl/assist_drive_pipe.sv
// assist_drive_pipe: pipelined eBike current demand with saturation flag and up/down slew limiting
module assist_drive_pipe #(
  parameter int TORQUE_W   = 12,
  parameter int TORQUE_MIN = 'h380,
  parameter int CURR_W     = 12,
  parameter int PROD_SHIFT = 15,
  parameter int SLEW_UP    = 64,
  parameter int SLEW_DN    = 128
) (
  input logic              clk,
  input logic              rst_n,
  assist_drive_pipe_if.slave bus
);
  localparam int PW = TORQUE_W + 18;
  localparam logic [TORQUE_W:0] L_TMIN = (TORQUE_W+1)'(TORQUE_MIN);
  localparam logic [CURR_W:0]   L_UP   = (CURR_W+1)'(SLEW_UP);
  localparam logic [CURR_W:0]   L_DN   = (CURR_W+1)'(SLEW_DN);
  logic                  r_v1, r_v2, r_v3, r_v4, r_out_vld;
  logic [TORQUE_W-1:0]   r_tpos;
  logic [8:0]            r_inc;
  logic [5:0]            r_cad;
  logic [2:0]            r_scl;
  logic                  r_np1, r_np2, r_np3;
  logic [TORQUE_W+8:0]   r_p1;
  logic [8:0]            r_p2;
  logic [PW-1:0]         r_prod;
  logic [CURR_W-1:0]     r_dem, r_t;
  logic                  r_sat4, r_sat;
  logic [13:0]           w_inc_sum;
  logic [8:0]            w_inc_lim;
  logic [5:0]            w_cad_f;
  logic [TORQUE_W:0]     w_tdiff;
  logic [TORQUE_W-1:0]   w_tpos;
  logic [PW-1:0]         w_shr;
  logic                  w_hi;
  logic [CURR_W:0]       w_diff, w_mag;
  logic [CURR_W-1:0]     w_step, w_next;
  // saturating to [-512,511] then clamping +256 to [0,511] equals clamping incline+256 directly
  assign w_inc_sum = {bus.incline[12], bus.incline} + 14'd256;
  assign w_inc_lim = w_inc_sum[13] ? 9'd0 : (|w_inc_sum[12:9] ? 9'd511 : w_inc_sum[8:0]);
  assign w_cad_f   = (bus.cadence > 5'd1) ? {1'b0, bus.cadence} + 6'd32 : 6'd0;
  assign w_tdiff   = {1'b0, bus.avg_torque} - L_TMIN;
  assign w_tpos    = w_tdiff[TORQUE_W] ? '0 : w_tdiff[TORQUE_W-1:0];
  assign w_shr     = r_prod >> PROD_SHIFT;
  assign w_hi      = |w_shr[PW-1:CURR_W];
  // sign of the widened difference tells the slew direction; the step always fits CURR_W bits
  assign w_diff    = {1'b0, r_dem} - {1'b0, r_t};
  assign w_mag     = w_diff[CURR_W] ? -w_diff : w_diff;
  assign w_step    = CURR_W'(w_diff[CURR_W] ? (w_mag > L_DN ? L_DN : w_mag) : (w_mag > L_UP ? L_UP : w_mag));
  assign w_next    = !bus.ramp_en ? r_dem : (w_diff[CURR_W] ? r_t - w_step : r_t + w_step);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_v1      <= 1'b0;
      r_v2      <= 1'b0;
      r_v3      <= 1'b0;
      r_v4      <= 1'b0;
      r_out_vld <= 1'b0;
      r_tpos    <= '0;
      r_inc     <= '0;
      r_cad     <= '0;
      r_scl     <= '0;
      r_np1     <= 1'b0;
      r_np2     <= 1'b0;
      r_np3     <= 1'b0;
      r_p1      <= '0;
      r_p2      <= '0;
      r_prod    <= '0;
      r_dem     <= '0;
      r_sat4    <= 1'b0;
      r_t       <= '0;
      r_sat     <= 1'b0;
    end else begin
      r_v1      <= bus.in_vld;
      r_v2      <= r_v1;
      r_v3      <= r_v2;
      r_v4      <= r_v3;
      r_out_vld <= r_v4;
      if (bus.in_vld) begin
        r_tpos <= w_tpos;
        r_inc  <= w_inc_lim;
        r_cad  <= w_cad_f;
        r_scl  <= bus.scale;
        r_np1  <= bus.not_pedaling;
      end
      if (r_v1) begin
        r_p1  <= (TORQUE_W+9)'(r_tpos) * (TORQUE_W+9)'(r_inc);
        r_p2  <= 9'(r_cad) * 9'(r_scl);
        r_np2 <= r_np1;
      end
      if (r_v2) begin
        r_prod <= PW'(r_p1) * PW'(r_p2);
        r_np3  <= r_np2;
      end
      if (r_v3) begin
        r_dem  <= r_np3 ? '0 : (w_hi ? '1 : w_shr[CURR_W-1:0]);
        r_sat4 <= !r_np3 && w_hi;
      end
      if (r_v4) begin
        r_t   <= w_next;
        r_sat <= r_sat4;
      end
    end
  assign bus.target_curr = r_t;
  assign bus.out_vld     = r_out_vld;
  assign bus.sat         = r_sat;
endmodule

// File: doc/assist_drive_pipe.md
# assist_drive_pipe

Parametrised, pipelined successor to the eBike desired-drive computation. Each strobed sample of averaged torque, cadence, incline, pedaling status and assist scale produces a motor current demand. A per-sample slew limiter then ramps the demand, and the result drives the PID/commutation path as `target_curr`. Compared with the previous generation it adds configurable widths and offset, a full 3-stage multiplier pipeline, a valid handshake, a saturation flag and up/down slew limiting.

## Interface
- `TORQUE_W`, 12: width of `avg_torque`.
- `TORQUE_MIN`, 12'h380: torque offset; torque at or below this value gives zero assist.
- `CURR_W`, 12: width of `target_curr`.
- `PROD_SHIFT`, 15: right shift applied to the product to form the demand.
- `SLEW_UP`, 64: maximum increase of `target_curr` per output update.
- `SLEW_DN`, 128: maximum decrease of `target_curr` per output update.

Ports (clock and reset first):
- `clk` in 1: system clock. One clock; reset is asynchronous and active-low.
- `rst_n` in 1: asynchronous active-low reset.
- `in_vld` in 1: sample strobe. All data inputs are captured on the edge where this is high.
- `avg_torque` in TORQUE_W: unsigned averaged torque.
- `cadence` in 5: unsigned cadence.
- `not_pedaling` in 1: forces the demand to 0.
- `incline` in 13: signed incline.
- `scale` in 3: unsigned assist level.
- `ramp_en` in 1: 1 enables slew limiting; 0 makes the output equal the demand.
- `target_curr` out CURR_W: slew-limited current demand.
- `out_vld` out 1: single-cycle pulse marking each `target_curr` update.
- `sat` out 1: demand saturated; aligned with and held like `target_curr`.

## Operation
- **Stage 1** (registered on `in_vld`):
  - incline saturated to signed 10 bits, range [-512, 511];
  - `incline_lim` = clamp(sat + 256, 0, 511), 9 bits;
  - `cadence_factor` = (cadence > 1) ? cadence + 32 : 0, 6 bits;
  - `torque_pos` = max(avg_torque − TORQUE_MIN, 0), computed with a TORQUE_W+1 bit signed subtract;
  - `scale` and `not_pedaling` registered alongside.
- **Stage 2**:
  - p1 = torque_pos × incline_lim (TORQUE_W+9 bits);
  - p2 = cadence_factor × scale (9 bits).
- **Stage 3**:
  - prod = p1 × p2 (TORQUE_W+18 bits, 30 at defaults);
  - if `not_pedaling`: demand = 0 and sat = 0;
  - else if any bit of prod above PROD_SHIFT+CURR_W−1 is set: demand = all ones and sat = 1;
  - otherwise demand = prod[PROD_SHIFT+CURR_W−1 : PROD_SHIFT] and sat = 0.
- **Stage 4 (slew)**, with T = `target_curr` and D = demand:
  - `ramp_en` = 0: T ← D;
  - D > T: T ← T + min(SLEW_UP, D − T);
  - D < T: T ← T − min(SLEW_DN, T − D);
  - D = T: T unchanged.
  - `sat` register updated with the stage-3 flag.
  - Differences are computed in CURR_W+1 bits; T never wraps.
- A valid bit travels with each stage. Registers of stages without a valid bit hold their value; only valid samples advance T.
- `ramp_en` is sampled at stage 4, not pipelined.

## Timing
- Reset: all pipeline registers and valid bits 0; `target_curr` = 0, `out_vld` = 0, `sat` = 0.
- Latency: `in_vld` high at edge N gives `out_vld` high for exactly the cycle after edge N+4, with the updated `target_curr` and `sat` in that cycle.
- Throughput: one sample per clock. Back-to-back `in_vld` gives back-to-back `out_vld`, and each sample advances T by at most one slew step.
- `in_vld` low: no `out_vld`; outputs hold.
- Reset asserted mid-pipeline: in-flight samples are discarded, and no `out_vld` occurs until 4 edges after the next `in_vld`.
- `not_pedaling` acts at stage 3, so T decays at SLEW_DN per valid sample rather than in one step (unless `ramp_en` = 0).

## Test plan
- **Nominal ramp-up.** Defaults, `ramp_en`=1. Inputs `avg_torque`=12'h480, `incline`=0, `cadence`=10, `scale`=4, `in_vld` pulsed once every 8 cycles. Demand is 336 (0x150). Required: successive `target_curr` values 64, 128, 192, 256, 320, 336, 336; `sat`=0; each `out_vld` pulse 5 cycles after its `in_vld`.
- **Bypass and latency.** Same inputs with `ramp_en`=0 and a single `in_vld`. Required: `target_curr`=0x150 in the cycle `out_vld` is high; `out_vld` high for 1 cycle only.
- **Saturation.** Inputs `avg_torque`=12'hFFF, `incline`=13'h0FF, `cadence`=31, `scale`=7, `ramp_en`=0. Product is 720,897,849. Required: `target_curr`=12'hFFF and `sat`=1.
- **Clamps to zero.** Each of the following must give demand 0:
  - `incline`=13'h1E00 (−512): `incline_lim`=0;
  - `avg_torque`=12'h37F;
  - `cadence`=1.

  Required: `target_curr`=0 and `sat`=0 in all three cases.
- **Pedaling stop.** Ramp to 0x150, then assert `not_pedaling` with `in_vld` every 8 cycles. Required: `target_curr` steps 208, 80, 0.
- **Pipelining and reset.** Drive `in_vld` on 4 consecutive cycles, then pull `rst_n` low asynchronously mid-flight. Required: `target_curr`, `out_vld` and `sat` go to 0 immediately, and no stale `out_vld` appears after reset is released.
